// File: rtl/ram_delay_mc.sv
// Multi-channel RAM-based delay line: a circular buffer shared by P_NCH channels.
// Optional build macro RAM_DELAY_MC_ZERO_FILL_EN forces q to zero on strobes with valid=0.
module ram_delay_mc #(
    parameter int P_NBITS_ADDR = 8,
    parameter int P_NBITS_DATA = 14,
    parameter int P_NCH        = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [P_NBITS_ADDR-1:0]         delay_len,
    input  logic                            wr,
    input  logic [P_NCH*P_NBITS_DATA-1:0]   d,
    input  logic                            prime,
    output logic [P_NCH*P_NBITS_DATA-1:0]   q,
    output logic                            q_wr,
    output logic                            valid
);

    localparam int W     = P_NCH * P_NBITS_DATA;
    localparam int DEPTH = 1 << P_NBITS_ADDR;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [P_NBITS_ADDR-1:0] wptr_q, wptr_d;
    logic [P_NBITS_ADDR-1:0] fcnt_q, fcnt_d;
    logic [P_NBITS_ADDR-1:0] dl_q, dl_d;
    logic                    s1_wr_q, s1_wr_d;
    logic                    s1_valid_q, s1_valid_d;
    logic [W-1:0]            q_q, q_d;
    logic                    q_wr_q, q_wr_d;
    logic                    valid_q, valid_d;

    logic [P_NBITS_ADDR-1:0] eff_len;
    logic [P_NBITS_ADDR-1:0] fcnt_base;
    logic [P_NBITS_ADDR-1:0] rd_addr;
    logic                    restart;
    logic                    wr_valid;
    logic [W-1:0]            rd_data_q;
    logic [W-1:0]            q_sel;

    logic [W-1:0] mem [DEPTH];

    // Fill tracking and write pointer; a restart in the same cycle as a write
    // makes that write count as the first one of the new fill.
    always_comb begin
        eff_len    = (delay_len == '0) ? P_NBITS_ADDR'(1) : delay_len;
        restart    = prime | (delay_len != dl_q);
        fcnt_base  = restart ? '0 : fcnt_q;
        wr_valid   = !restart && (state_q == ST_READY);
        rd_addr    = wptr_q - eff_len;
        dl_d       = delay_len;
        wptr_d     = wptr_q;
        fcnt_d     = fcnt_base;
        state_d    = state_q;
        s1_wr_d    = wr;
        s1_valid_d = wr & wr_valid;
        if (wr) begin
            wptr_d = wptr_q + P_NBITS_ADDR'(1);
            if (fcnt_base < eff_len) begin
                fcnt_d = fcnt_base + P_NBITS_ADDR'(1);
            end
        end
        case (state_q)
            ST_FILL: begin
                if (fcnt_d == eff_len) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (restart && (fcnt_d != eff_len)) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Buffer storage with registered read; contents are never cleared.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr_q] <= d;
        end
        rd_data_q <= mem[rd_addr];
    end

    generate
        for (genvar gi = 0; gi < P_NCH; gi++) begin : g_chan
`ifdef RAM_DELAY_MC_ZERO_FILL_EN
            assign q_sel[gi*P_NBITS_DATA +: P_NBITS_DATA] =
                s1_valid_q ? rd_data_q[gi*P_NBITS_DATA +: P_NBITS_DATA] : '0;
`else
            assign q_sel[gi*P_NBITS_DATA +: P_NBITS_DATA] =
                rd_data_q[gi*P_NBITS_DATA +: P_NBITS_DATA];
`endif
        end
    endgenerate

    // Output stage: q only moves on a strobe, otherwise it holds.
    always_comb begin
        q_d     = s1_wr_q ? q_sel : q_q;
        q_wr_d  = s1_wr_q;
        valid_d = s1_wr_q & s1_valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            wptr_q     <= '0;
            fcnt_q     <= '0;
            dl_q       <= '0;
            s1_wr_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            q_q        <= '0;
            q_wr_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            fcnt_q     <= fcnt_d;
            dl_q       <= dl_d;
            s1_wr_q    <= s1_wr_d;
            s1_valid_q <= s1_valid_d;
            q_q        <= q_d;
            q_wr_q     <= q_wr_d;
            valid_q    <= valid_d;
        end
    end

    assign q     = q_q;
    assign q_wr  = q_wr_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_ram_delay_mc.sv
// Directed bench for ram_delay_mc built with a 16-entry buffer so wrap-around is exercised.
module tb_ram_delay_mc;

    localparam int A  = 4;
    localparam int N  = 14;
    localparam int CH = 4;

    logic                clk;
    logic                rst_n;
    logic [A-1:0]        delay_len;
    logic                wr;
    logic [CH*N-1:0]     d;
    logic                prime;
    logic [CH*N-1:0]     q;
    logic                q_wr;
    logic                valid;

    int checks = 0;
    int errors = 0;

    ram_delay_mc #(
        .P_NBITS_ADDR (A),
        .P_NBITS_DATA (N),
        .P_NCH        (CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .delay_len (delay_len),
        .wr        (wr),
        .d         (d),
        .prime     (prime),
        .q         (q),
        .q_wr      (q_wr),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CH*N-1:0] rep(input int v);
        logic [N-1:0] s;
        s = N'(v);
        return {CH{s}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks one output strobe: q_wr, valid, and q when it is defined.
    task automatic chk_out(input string tag, input int j, input logic ev, input int ed);
        $display("txn %s write=%0d q_wr=%0b valid=%0b q=%0h", tag, j, q_wr, valid, q);
        chk({tag, "_qwr"}, 64'(q_wr), 64'(1));
        chk({tag, "_valid"}, 64'(valid), 64'(ev));
        if (ev) begin
            chk({tag, "_q"}, 64'(q), 64'(rep(ed)));
        end
`ifdef RAM_DELAY_MC_ZERO_FILL_EN
        else begin
            chk({tag, "_qzero"}, 64'(q), 64'(0));
        end
`endif
    endtask

    initial begin
        logic ev;
        int   ed;

        rst_n     = 1'b0;
        wr        = 1'b0;
        prime     = 1'b0;
        d         = '0;
        delay_len = 4'd4;
        tick();
        tick();
        chk("rst_q", 64'(q), 64'(0));
        chk("rst_qwr", 64'(q_wr), 64'(0));
        chk("rst_valid", 64'(valid), 64'(0));
        rst_n = 1'b1;

        // Continuous writes, delay 4, d=k.
        for (int k = 1; k <= 9; k++) begin
            wr = (k <= 8);
            d  = rep(k);
            tick();
            if (k == 1) begin
                chk("r031_lat", 64'(q_wr), 64'(0));
            end else begin
                chk_out("r031", k - 1, (k - 1) > 4, k - 5);
            end
        end
        wr = 1'b0;
        tick();
        chk("r018_idle", 64'(q_wr), 64'(0));
        chk("r018_hold", 64'(q), 64'(rep(4)));

        // Gapped writes, delay 3.
        delay_len = 4'd3;
        for (int j = 1; j <= 5; j++) begin
            wr = 1'b1;
            d  = rep(10 * j);
            tick();
            chk("r032_gap", 64'(q_wr), 64'(0));
            wr = 1'b0;
            tick();
            chk_out("r032", j, j > 3, 10 * (j - 3));
        end

        // Delay 5 steady state, prime coincident with write 9.
        delay_len = 4'd5;
        for (int k = 1; k <= 21; k++) begin
            wr    = (k <= 20);
            d     = rep(100 + k);
            prime = (k == 9);
            tick();
            if (k >= 2) begin
                ev = ((k - 1) >= 6 && (k - 1) <= 8) || (k - 1) >= 14;
                chk_out("r033", k - 1, ev, 100 + (k - 1) - 5);
            end
        end
        prime = 1'b0;

        // Delay 6 changing to 2 at write 10.
        for (int k = 1; k <= 17; k++) begin
            wr        = (k <= 16);
            d         = rep(200 + k);
            delay_len = (k <= 9) ? 4'd6 : 4'd2;
            tick();
            if (k >= 2) begin
                ev = ((k - 1) >= 7 && (k - 1) <= 9) || (k - 1) >= 12;
                ed = ((k - 1) <= 9) ? 200 + (k - 1) - 6 : 200 + (k - 1) - 2;
                chk_out("r034", k - 1, ev, ed);
            end
        end

        // Maximum delay with several wraps of the 16-entry buffer.
        delay_len = 4'd15;
        for (int k = 1; k <= 41; k++) begin
            wr = (k <= 40);
            d  = rep(300 + k);
            tick();
            if (k >= 2) begin
                chk_out("r035_wrap", k - 1, (k - 1) >= 16, 300 + (k - 1) - 15);
            end
        end

        // delay_len=0 acts as a delay of one write.
        delay_len = 4'd0;
        for (int k = 1; k <= 7; k++) begin
            wr = (k <= 6);
            d  = rep(400 + k);
            tick();
            if (k >= 2) begin
                chk_out("r035_zero", k - 1, (k - 1) >= 2, 400 + (k - 1) - 1);
            end
        end

        // Reset with writes in flight.
        wr = 1'b1;
        d  = rep(500);
        tick();
        d  = rep(501);
        tick();
        chk_out("r036_pre", 500, 1'b1, 406);
        wr    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("r036_q", 64'(q), 64'(0));
        chk("r036_qwr", 64'(q_wr), 64'(0));
        chk("r036_valid", 64'(valid), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r026_nostrobe", 64'(q_wr), 64'(0));
        end

        // Fresh fill after reset, delay still 0 (acts as 1).
        wr = 1'b1;
        d  = rep(600);
        tick();
        wr = 1'b0;
        tick();
        chk_out("r028_first", 1, 1'b0, 0);
        wr = 1'b1;
        d  = rep(601);
        tick();
        wr = 1'b0;
        tick();
        chk_out("r028_second", 2, 1'b1, 600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
